// File: rtl/seq_detect_ctrl.sv
// Run controller for a programmable serial pattern matcher: accepts a job
// configuration, fills a W-bit shift window, counts overlapping matches and retires with a status.
module seq_detect_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [TO_W-1:0]  cfg_timeout,
  input  logic             in_vld,
  input  logic             in,
  input  logic             abort,
  output logic             busy,
  output logic             match,
  output logic             done,
  output logic [1:0]       done_status,
  output logic [CNT_W-1:0] match_cnt
);

  // state | meaning
  // IDLE  | waiting for a configuration
  // FILL  | shifting in the first W bits, no match evaluation until full
  // RUN   | window full, every accepted bit is match-evaluated
  // DONE  | one-cycle retire, done pulse
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam int FW = $clog2(W + 1);

  state_t            state, next_state;
  logic [W-1:0]      pat_q, mask_q, window;
  logic [CNT_W-1:0]  target_q, cnt_inc;
  logic [TO_W-1:0]   timeout_q, cyc_cnt;
  logic [FW-1:0]     fill_cnt;
  logic [W-1:0]      new_window;
  logic              accept, active, full, hit, hit_target, timeout_hit;

  assign accept      = (state == IDLE) && cfg_vld;
  assign active      = (state == FILL) || (state == RUN);
  assign new_window  = {window[W-2:0], in};
  assign full        = in_vld && ((state == RUN) ||
                       ((state == FILL) && (fill_cnt == FW'(W - 1))));
  assign hit         = full && (((new_window ^ pat_q) & mask_q) == '0);
  assign cnt_inc     = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  assign hit_target  = hit && (cnt_inc == target_q);
  assign timeout_hit = (timeout_q != '0) && (cyc_cnt == timeout_q - TO_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (cfg_vld) next_state = FILL;
      FILL, RUN: begin
        if (abort || hit_target || timeout_hit) next_state = DONE;
        else if ((state == FILL) && full)       next_state = RUN;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cfg_rdy = (state == IDLE);
    busy    = active;
    done    = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q       <= '0;
      mask_q      <= '0;
      target_q    <= '0;
      timeout_q   <= '0;
      window      <= '0;
      fill_cnt    <= '0;
      cyc_cnt     <= '0;
      match_cnt   <= '0;
      done_status <= 2'b00;
      match       <= 1'b0;
    end else if (accept) begin
      pat_q       <= cfg_pattern;
      mask_q      <= cfg_mask;
      target_q    <= (cfg_count == '0) ? CNT_W'(1) : cfg_count;
      timeout_q   <= cfg_timeout;
      window      <= '0;
      fill_cnt    <= '0;
      cyc_cnt     <= '0;
      match_cnt   <= '0;
      done_status <= 2'b00;
      match       <= 1'b0;
    end else if (active) begin
      cyc_cnt <= cyc_cnt + TO_W'(1);
      if (in_vld) window <= new_window;
      if ((state == FILL) && in_vld) fill_cnt <= fill_cnt + FW'(1);
      // an abort on the same cycle as a match still shifts the bit but credits nothing
      match <= hit && !abort;
      if (hit && !abort) match_cnt <= cnt_inc;
      if (abort)            done_status <= 2'b10;
      else if (hit_target)  done_status <= 2'b00;
      else if (timeout_hit) done_status <= 2'b01;
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for a programmable serial pattern matcher. Accepts a job configuration over a valid/ready handshake: pattern, care-mask, required match count and timeout. It then primes and arms an internal W-bit shift window, counts overlapping matches on a qualified serial bit stream, and retires the job with a status code. It sits between the test/control logic and the serial input, turning the fixed-pattern detector into a reusable, software-sequenced resource.

## Interface
- W, 8, pattern/window width in bits (W ≥ 2)
- CNT_W, 8, width of match-count target and counter
- TO_W, 16, width of timeout (clock cycles)

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_vld  in  1  configuration offered
- cfg_rdy  out  1  controller idle; accepts configuration
- cfg_pattern  in  W  pattern; bit W-1 is the oldest bit of the window
- cfg_mask  in  W  1 = bit compared, 0 = don't-care
- cfg_count  in  CNT_W  matches required to complete; 0 is treated as 1
- cfg_timeout  in  TO_W  cycle budget; 0 = no timeout
- in_vld  in  1  serial bit qualifier
- in  in  1  serial data bit
- abort  in  1  terminate the current job
- busy  out  1  job in progress (FILL or RUN)
- match  out  1  one-cycle pulse per match
- done  out  1  one-cycle pulse at job end
- done_status  out  2  00 count reached, 01 timeout, 10 abort; held until next accept
- match_cnt  out  CNT_W  matches this job; saturates at all-ones; held until next accept

## Operation
- States: IDLE, FILL, RUN, DONE. cfg_rdy = (state == IDLE); busy = FILL or RUN.
- IDLE: when cfg_vld & cfg_rdy, latch the configuration, then clear the shift window, fill counter, cycle counter, match_cnt and done_status. Go to FILL.
- Shifting: in FILL and RUN, each in_vld cycle sets window = {window[W-2:0], in}. Cycles without in_vld hold the window. No shifting in IDLE or DONE.
- FILL: the fill counter counts accepted bits. The W-th accepted bit moves the state to RUN, and that bit is match-evaluated.
- Match: evaluated only on a cycle with in_vld when the new window is full. The condition is ((new_window ^ pattern) & mask) == 0. Overlapping matches are counted; the window is not cleared after a match. mask = 0 matches every full window.
- Cycle counter: increments every cycle in FILL and RUN.
- End conditions, evaluated each FILL/RUN cycle, in priority order:
  - abort → status 10
  - this cycle's match makes match_cnt reach the target → status 00
  - cfg_timeout ≠ 0 and cycle counter == cfg_timeout-1 → status 01
  - Any of these moves the state to DONE.
- DONE: lasts one cycle, then the state goes to IDLE.
- abort in IDLE or DONE is ignored. cfg_vld while busy is ignored and never queued.

## Timing
- Reset values: state IDLE, cfg_rdy 1, busy 0, match 0, done 0, done_status 00, match_cnt 0. Window and counters are 0.
- Reset asserted mid-job takes effect immediately (asynchronous). No done pulse is generated for the killed job.
- Accept at cycle t0: first FILL cycle is t0+1. busy=1 from t0+1 and cfg_rdy=0 from t0+1.
- Bit accepted at cycle t that completes a match: match=1 and match_cnt incremented at t+1 (registered).
- Completing match at t:
  - t+1: done=1, state DONE, done_status=00, busy=0
  - t+2: cfg_rdy=1
- abort at t: done=1 with status 10 at t+1. A bit accepted at t is shifted, but no match is credited.
- Timeout T ≠ 0: done=1 with status 01 exactly T cycles after the first FILL cycle. If the target is met on the last budget cycle, status is 00.

## Test plan
- Basic match:
  - Stimulus: pattern 0x9A, mask 0xFF, count 1, timeout 0; bits 1,0,0,1,1,0,1,0, one per cycle.
  - Response: match and done one cycle after the 8th bit; status 00; match_cnt 1; cfg_rdy 1 the cycle after.
- Overlap:
  - Stimulus: pattern 0xAA, mask 0xFF, count 3; bits 101010101010 continuous.
  - Response: matches after bits 8, 10 and 12; done after bit 12; match_cnt 3.
- Fill and gaps:
  - Stimulus: mask 0x00, count 1; 8 valid bits interleaved with idle cycles.
  - Response: no match before the 8th valid bit; match and done the cycle after it.
- Timeout:
  - Stimulus: pattern 0xFF, mask 0xFF, count 1, timeout 20; all zeros.
  - Response: done 20 cycles after the first FILL cycle; status 01; match_cnt 0.
- Abort and busy config:
  - Stimulus: cfg_vld held during RUN; abort pulse on a cycle that also holds a matching bit.
  - Response: cfg_rdy 0 and no re-latch during RUN; done next cycle with status 10; match not credited.
- Async reset:
  - Stimulus: rst mid-RUN.
  - Response: busy 0, cfg_rdy 1 and match_cnt 0 immediately; no done pulse; the next configuration is accepted normally.
